lcd_win_capture: RTL
====================

// Module: lcd_win_capture
// PURPOSE
//  Downstream of the LCD controller: captures each 16-pixel output window (4x4, row-major) from its
//  dataout/output_valid stream into a ping-pong pair of 16x8 banks, then replays each full window
//  to the panel/scan-out side over a valid/ready handshake. Decouples controller output timing from
//  a panel that may stall; detects and counts-through windows lost to back-pressure.
// PARAMETERS
//  DW    8   pixel width in bits
//  NPIX  16  pixels per window (fixed 4x4; implementation may assume 16, counters 4 bits)
// PORTS
//  clk        in   1   rising-edge clock (single clock domain)
//  reset      in   1   asynchronous, active-low reset
//  pix_in     in   DW  pixel from controller dataout
//  pix_valid  in   1   qualifies pix_in (controller output_valid); one pixel per cycle high
//  out_data   out  DW  pixel being offered to panel
//  out_valid  out  1   out_data valid
//  out_ready  in   1   panel accepts beat when out_valid & out_ready
//  out_idx    out  4   index 0..15 of out_data within window
//  out_last   out  1   high with beat 15
//  ovf        out  1   sticky: at least one window dropped since reset
//  win_min    out  DW  (CAP_MINMAX_EN only) min of window being read
//  win_max    out  DW  (CAP_MINMAX_EN only) max of window being read
// BEHAVIOUR
//  Reset (reset=0, async): out_valid=0, out_last=0, out_idx=0, ovf=0, out_data=0, both bank-full
//   flags=0, wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, drop=0; partial windows discarded.
//  Write side: wr_cnt counts accepted pix_valid cycles 0..15, wraps 15->0. pix_valid gaps allowed.
//   At wr_cnt==0 a window start is decided: target bank wr_bank free -> store mode; full -> drop
//   mode for all 16 pixels of that window (not stored), ovf<=1, wr_bank unchanged.
//   Store: bank[wr_bank][wr_cnt]<=pix_in. On pixel 15 (store mode): full[wr_bank]<=1, wr_bank toggles.
//  Read side FSM: R_IDLE -> R_SEND when full[rd_bank]=1. In R_SEND: out_valid=1,
//   out_data=bank[rd_bank][rd_cnt], out_idx=rd_cnt, out_last=(rd_cnt==15). Beat accepted on
//   out_valid&out_ready: rd_cnt++. On accepted beat 15: full[rd_bank]<=0, rd_bank toggles, rd_cnt<=0;
//   next state R_SEND if other bank full, else R_IDLE (back-to-back windows, no bubble).
//  Stall: while out_valid&!out_ready, out_data/out_idx/out_last held stable.
//  Latency: pixel 15 stored at edge N -> out_valid=1 after edge N (first beat cycle N+1) when idle.
//  Simultaneous free/start: if last beat of bank B accepted in same cycle as a window start
//   targeting B, freeing wins: window stored, no drop, ovf unchanged.
//  Simultaneous set/clear of different banks in one cycle both take effect.
//  out_data/out_idx/out_last are combinational from registered state; all state registered.
//  ovf cleared only by reset.
// CONFIGURATION
//  CAP_MINMAX_EN defined: during store, running min/max per bank tracked (pixel 0 initialises);
//   win_min/win_max present and valid whenever out_valid=1, for rd_bank's window; 0 at reset.
//  Not defined: win_min/win_max ports and tracking logic absent; all else identical.
// TESTING
//  1 reset low mid-window (after 7 pixels), release, send 16 px 0..15, out_ready=1 -> out_valid
//    1 cycle after 16th px, beats 0..15 in order, out_last on idx 15, ovf=0.
//  2 two windows back-to-back (0..15, 100..115), out_ready=1 -> 32 beats contiguous, no bubble.
//  3 out_ready=0, send 3 windows A,B,C -> A,B stored, C dropped, ovf=1; release ready ->
//    A then B output, then out_valid=0; 4th window D stored and output normally.
//  4 out_ready toggled pseudo-randomly, pix_valid with gaps -> data/idx stable during stall,
//    every beat matches scoreboard, no loss while at most one window outstanding.
//  5 Bank A held full, B full; release ready so A's beat 15 accepted same cycle as window start
//    to A -> window stored, ovf stays 0.
//  6 CAP_MINMAX_EN: window {7,200,3,...,50} -> win_min=3, win_max=200 on all its beats;
//    build without macro compiles with ports absent.

Source files
------------

// File: rtl/lcd_win_capture.sv
// lcd_win_capture: captures 4x4 pixel windows from the LCD controller output
// stream into a ping-pong pair of 16-entry banks. Each full window is replayed
// to the panel side over a valid/ready handshake. A window that arrives while
// its target bank is still occupied is dropped whole, and the sticky ovf flag
// records the loss.
// Optional feature macro: CAP_MINMAX_EN adds per-window min/max tracking and
// the win_min/win_max outputs.
module lcd_win_capture #(
   parameter int DW   = 8,
   parameter int NPIX = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] pix_in,
   input  logic          pix_valid,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [3:0]    out_idx,
   output logic          out_last,
   output logic          ovf
`ifdef CAP_MINMAX_EN
   ,
   output logic [DW-1:0] win_min,
   output logic [DW-1:0] win_max
`endif
);

   localparam logic [3:0] LAST_IDX = 4'(NPIX - 1);

   typedef enum logic {R_IDLE, R_SEND} rd_state_t;

   rd_state_t     state, state_nxt;
   logic [DW-1:0] bank [0:1][0:15];
   logic [1:0]    full, full_set, full_clr, full_nxt;
   logic          wr_bank, rd_bank, drop;
   logic [3:0]    wr_cnt, rd_cnt;
   logic          beat, last_beat, bank_free, store;

   // Handshake, bank-availability and full-flag update decode
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
      full_set  = '0;
      full_clr  = '0;
      out_valid = (state == R_SEND);
      beat      = out_valid && out_ready;
      last_beat = beat && (rd_cnt == LAST_IDX);
      // A bank whose last beat leaves this cycle already counts as free.
      bank_free = !full[wr_bank] || (last_beat && (rd_bank == wr_bank));
      store     = pix_valid && ((wr_cnt == '0) ? bank_free : !drop);
      if (store && (wr_cnt == LAST_IDX)) full_set[wr_bank] = 1'b1;
      if (last_beat)                     full_clr[rd_bank] = 1'b1;
      full_nxt  = (full & ~full_clr) | full_set;
   end

   // Read FSM next state: looks at next-cycle full flags so a completed window starts output without a bubble
   always_comb begin
      state_nxt = state;
      case (state)
         R_IDLE:  if (full_nxt[rd_bank]) state_nxt = R_SEND;
         R_SEND:  if (last_beat) state_nxt = full_nxt[!rd_bank] ? R_SEND : R_IDLE;
         default: state_nxt = R_IDLE;
      endcase
   end

   // Write-side counters, drop decision at window start, sticky overflow
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_cnt  <= '0;
         wr_bank <= 1'b0;
         drop    <= 1'b0;
         ovf     <= 1'b0;
      end else if (pix_valid) begin
         // NOTE: non-blocking assignments make every register here see pre-edge values, independent of statement order.
         wr_cnt <= wr_cnt + 4'd1;
         if (wr_cnt == '0) begin
            drop <= !bank_free;
            if (!bank_free) ovf <= 1'b1;
         end
         if (store && (wr_cnt == LAST_IDX)) wr_bank <= !wr_bank;
      end
   end

   // Pixel storage
   always_ff @(posedge clk) begin
      // NOTE: the banks are deliberately not reset; the full flags gate every read, so stale contents are never seen.
      if (store) bank[wr_bank][wr_cnt] <= pix_in;
   end

   // Bank-full flags: set and clear of different banks in one cycle both apply
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) full <= '0;
      else        full <= full_nxt;
   end

   // Read-side state, beat counter and bank pointer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= R_IDLE;
         rd_cnt  <= '0;
         rd_bank <= 1'b0;
      end else begin
         state <= state_nxt;
         if (beat)      rd_cnt  <= rd_cnt + 4'd1;
         if (last_beat) rd_bank <= !rd_bank;
      end
   end

   // Output beat: combinational from registered pointers, zero while idle
   always_comb begin
      out_data = out_valid ? bank[rd_bank][rd_cnt] : '0;
      out_idx  = rd_cnt;
      out_last = out_valid && (rd_cnt == LAST_IDX);
   end

`ifdef CAP_MINMAX_EN
   logic [DW-1:0] min_r [0:1];
   logic [DW-1:0] max_r [0:1];

   // Running min/max per bank, seeded by pixel 0 of each stored window
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         min_r[0] <= '0;
         min_r[1] <= '0;
         max_r[0] <= '0;
         max_r[1] <= '0;
      end else if (store) begin
         if (wr_cnt == '0) begin
            min_r[wr_bank] <= pix_in;
            max_r[wr_bank] <= pix_in;
         end else begin
            if (pix_in < min_r[wr_bank]) min_r[wr_bank] <= pix_in;
            if (pix_in > max_r[wr_bank]) max_r[wr_bank] <= pix_in;
         end
      end
   end

   // Statistics of the window currently being read
   always_comb begin
      win_min = min_r[rd_bank];
      win_max = max_r[rd_bank];
   end
`endif

endmodule
